// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between two req/ack requesters.
// Port 0 is the CPU load/store stage, port 1 the debug loader or DMA engine.
// One transaction is in flight at a time: IDLE -> BUSY -> DONE -> IDLE.
// Optional watchdog (define DMEM_ARB_TIMEOUT_EN): a BUSY access that the
// memory never completes is forced to DONE after TIMEOUT_CYCLES cycles and
// flagged on oTimeout.
module dmem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int RR_EN          = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iReq0,
    input  logic              iWr0,
    input  logic [ADDR_W-1:0] iAddr0,
    input  logic [DATA_W-1:0] iWData0,
    output logic              oAck0,
    output logic [DATA_W-1:0] oRData0,
    input  logic              iReq1,
    input  logic              iWr1,
    input  logic [ADDR_W-1:0] iAddr1,
    input  logic [DATA_W-1:0] iWData1,
    output logic              oAck1,
    output logic [DATA_W-1:0] oRData1,
    output logic              oMemRd,
    output logic              oMemWr,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [DATA_W-1:0] oMemWData,
    input  logic [DATA_W-1:0] iMemRData,
    input  logic              iMemAccessable,
    output logic              oGrant,
`ifdef DMEM_ARB_TIMEOUT_EN
    output logic              oTimeout,
`endif
    output logic              oBusy
);

    // The watchdog counter is 16 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
        $error("dmem_arbiter: TIMEOUT_CYCLES must be within 1..65536");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic              grant_q,     grant_d;
    logic              mem_rd_q,    mem_rd_d;
    logic              mem_wr_q,    mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              ack0_q,      ack0_d;
    logic              ack1_q,      ack1_d;
    logic [DATA_W-1:0] rdata0_q,    rdata0_d;
    logic [DATA_W-1:0] rdata1_q,    rdata1_d;
    logic              winner;
    logic              sel_wr;

`ifdef DMEM_ARB_TIMEOUT_EN
    // The counter starts at zero on BUSY entry, so the last allowed value is limit-1.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0]       cnt_q,       cnt_d;
    logic              timeout_q,   timeout_d;
`endif

    // Next-state and next-output computation for the whole arbiter.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
`ifdef DMEM_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
`endif

        if (iReq0 && iReq1) begin
            winner = (RR_EN != 0) ? ~grant_q : 1'b0;
        end else begin
            winner = iReq1;
        end
        sel_wr = winner ? iWr1 : iWr0;

        case (state_q)
            IDLE: begin
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
                if (iReq0 || iReq1) begin
                    grant_d     = winner;
                    mem_addr_d  = winner ? iAddr1 : iAddr0;
                    mem_wdata_d = winner ? iWData1 : iWData0;
                    mem_rd_d    = ~sel_wr;
                    mem_wr_d    = sel_wr;
                    state_d     = BUSY;
`ifdef DMEM_ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            BUSY: begin
                if (iMemAccessable) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    if (mem_rd_q) begin
                        if (grant_q) rdata1_d = iMemRData;
                        else         rdata0_d = iMemRData;
                    end
                    ack0_d  = ~grant_q;
                    ack1_d  = grant_q;
                    state_d = DONE;
                end
`ifdef DMEM_ARB_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    mem_rd_d  = 1'b0;
                    mem_wr_d  = 1'b0;
                    ack0_d    = ~grant_q;
                    ack1_d    = grant_q;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops the strobes without a clock edge.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q     <= IDLE;
            grant_q     <= 1'b1;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
`ifdef DMEM_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
`ifdef DMEM_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign oMemRd    = mem_rd_q;
    assign oMemWr    = mem_wr_q;
    assign oMemAddr  = mem_addr_q;
    assign oMemWData = mem_wdata_q;
    assign oAck0     = ack0_q;
    assign oAck1     = ack1_q;
    assign oRData0   = rdata0_q;
    assign oRData1   = rdata1_q;
    assign oGrant    = grant_q;
    assign oBusy     = (state_q != IDLE);
`ifdef DMEM_ARB_TIMEOUT_EN
    assign oTimeout  = timeout_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: two arbiter instances share every input; "rr" uses
// round-robin, "fp" fixed priority. Single-requester vectors expect identical
// behaviour from both; contention sequences expect different winners.
module tb_dmem_arbiter;

    logic        iClk;
    logic        iRst;
    logic        iReq0, iWr0, iReq1, iWr1;
    logic [31:0] iAddr0, iWData0, iAddr1, iWData1;
    logic [31:0] iMemRData;
    logic        iMemAccessable;

    logic        rrAck0, rrAck1, rrMemRd, rrMemWr, rrGrant, rrBusy;
    logic [31:0] rrRData0, rrRData1, rrMemAddr, rrMemWData;
    logic        fpAck0, fpAck1, fpMemRd, fpMemWr, fpGrant, fpBusy;
    logic [31:0] fpRData0, fpRData1, fpMemAddr, fpMemWData;
`ifdef DMEM_ARB_TIMEOUT_EN
    logic        rrTimeout, fpTimeout;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic        req0;
        logic        wr0;
        logic [31:0] addr0;
        logic [31:0] wdata0;
        logic        req1;
        logic        wr1;
        logic [31:0] addr1;
        logic [31:0] wdata1;
        logic        acc;
        logic [31:0] memRData;
        logic        expRd;
        logic        expWr;
        logic [31:0] expAddr;
        logic [31:0] expWData;
        logic        expAck0;
        logic        expAck1;
        logic [31:0] expRData0;
        logic [31:0] expRData1;
        logic        expGrant;
        logic        expBusy;
    } vec_t;

    vec_t vecs [15];

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1), .TIMEOUT_CYCLES(4)) rr (
        .iClk(iClk), .iRst(iRst),
        .iReq0(iReq0), .iWr0(iWr0), .iAddr0(iAddr0), .iWData0(iWData0),
        .oAck0(rrAck0), .oRData0(rrRData0),
        .iReq1(iReq1), .iWr1(iWr1), .iAddr1(iAddr1), .iWData1(iWData1),
        .oAck1(rrAck1), .oRData1(rrRData1),
        .oMemRd(rrMemRd), .oMemWr(rrMemWr), .oMemAddr(rrMemAddr),
        .oMemWData(rrMemWData), .iMemRData(iMemRData),
        .iMemAccessable(iMemAccessable), .oGrant(rrGrant),
`ifdef DMEM_ARB_TIMEOUT_EN
        .oTimeout(rrTimeout),
`endif
        .oBusy(rrBusy)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(0), .TIMEOUT_CYCLES(4)) fp (
        .iClk(iClk), .iRst(iRst),
        .iReq0(iReq0), .iWr0(iWr0), .iAddr0(iAddr0), .iWData0(iWData0),
        .oAck0(fpAck0), .oRData0(fpRData0),
        .iReq1(iReq1), .iWr1(iWr1), .iAddr1(iAddr1), .iWData1(iWData1),
        .oAck1(fpAck1), .oRData1(fpRData1),
        .oMemRd(fpMemRd), .oMemWr(fpMemWr), .oMemAddr(fpMemAddr),
        .oMemWData(fpMemWData), .iMemRData(iMemRData),
        .iMemAccessable(iMemAccessable), .oGrant(fpGrant),
`ifdef DMEM_ARB_TIMEOUT_EN
        .oTimeout(fpTimeout),
`endif
        .oBusy(fpBusy)
    );

    // Free-running 10 ns clock.
    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checkOutput(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic applyStimulus(input vec_t v);
        iReq0          = v.req0;
        iWr0           = v.wr0;
        iAddr0         = v.addr0;
        iWData0        = v.wdata0;
        iReq1          = v.req1;
        iWr1           = v.wr1;
        iAddr1         = v.addr1;
        iWData1        = v.wdata1;
        iMemAccessable = v.acc;
        iMemRData      = v.memRData;
    endtask

    task automatic clearInputs();
        iReq0 = 0; iWr0 = 0; iAddr0 = 0; iWData0 = 0;
        iReq1 = 0; iWr1 = 0; iAddr1 = 0; iWData1 = 0;
        iMemAccessable = 0; iMemRData = 0;
    endtask

    task automatic stepCycle();
        @(posedge iClk);
        #1;
    endtask

    task automatic doReset();
        iRst = 1'b1;
        clearInputs();
        stepCycle();
        iRst = 1'b0;
    endtask

    task automatic checkDut(input string tag, input int i, input vec_t v,
                            input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic a0, input logic a1,
                            input logic [31:0] r0, input logic [31:0] r1,
                            input logic g, input logic b);
        checkBit   ($sformatf("%s vec%0d memRd", tag, i),    rd,    v.expRd);
        checkBit   ($sformatf("%s vec%0d memWr", tag, i),    wr,    v.expWr);
        checkOutput($sformatf("%s vec%0d memAddr", tag, i),  addr,  v.expAddr);
        checkOutput($sformatf("%s vec%0d memWData", tag, i), wdata, v.expWData);
        checkBit   ($sformatf("%s vec%0d ack0", tag, i),     a0,    v.expAck0);
        checkBit   ($sformatf("%s vec%0d ack1", tag, i),     a1,    v.expAck1);
        checkOutput($sformatf("%s vec%0d rdata0", tag, i),   r0,    v.expRData0);
        checkOutput($sformatf("%s vec%0d rdata1", tag, i),   r1,    v.expRData1);
        checkBit   ($sformatf("%s vec%0d grant", tag, i),    g,     v.expGrant);
        checkBit   ($sformatf("%s vec%0d busy", tag, i),     b,     v.expBusy);
    endtask

    initial begin
        // req0 wr0 addr0 wdata0 | req1 wr1 addr1 wdata1 | acc memRData | rd wr addr wdata ack0 ack1 rdata0 rdata1 grant busy
        vecs[0]  = '{1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0,  32'h0,        1, 32'hBAD0BAD0,
                     0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0,        32'h0,        0, 1};
        vecs[1]  = '{1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0,  32'h0,        1, 32'hBAD0BAD0,
                     0, 0, 32'h10, 32'hDEADBEEF, 1, 0, 32'h0,        32'h0,        0, 1};
        vecs[2]  = '{0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0,  32'h0,        1, 32'hBAD0BAD0,
                     0, 0, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0,        32'h0,        0, 0};
        vecs[3]  = '{0, 0, 32'h0,  32'h0,        1, 0, 32'h10, 32'h55,       0, 32'hDEADBEEF,
                     1, 0, 32'h10, 32'h55,       0, 0, 32'h0,        32'h0,        1, 1};
        vecs[4]  = '{0, 0, 32'h0,  32'h0,        1, 0, 32'h10, 32'h55,       0, 32'hDEADBEEF,
                     1, 0, 32'h10, 32'h55,       0, 0, 32'h0,        32'h0,        1, 1};
        vecs[5]  = '{0, 0, 32'h0,  32'h0,        1, 0, 32'h10, 32'h55,       0, 32'hDEADBEEF,
                     1, 0, 32'h10, 32'h55,       0, 0, 32'h0,        32'h0,        1, 1};
        vecs[6]  = '{0, 0, 32'h0,  32'h0,        1, 0, 32'h10, 32'h55,       0, 32'hDEADBEEF,
                     1, 0, 32'h10, 32'h55,       0, 0, 32'h0,        32'h0,        1, 1};
        vecs[7]  = '{0, 0, 32'h0,  32'h0,        1, 0, 32'h10, 32'h55,       1, 32'hDEADBEEF,
                     0, 0, 32'h10, 32'h55,       0, 1, 32'h0,        32'hDEADBEEF, 1, 1};
        vecs[8]  = '{0, 0, 32'h0,  32'h0,        0, 0, 32'h10, 32'h55,       1, 32'hDEADBEEF,
                     0, 0, 32'h10, 32'h55,       0, 0, 32'h0,        32'hDEADBEEF, 1, 0};
        vecs[9]  = '{0, 0, 32'h0,  32'h0,        1, 1, 32'h20, 32'h12345678, 1, 32'hBAD0BAD0,
                     0, 1, 32'h20, 32'h12345678, 0, 0, 32'h0,        32'hDEADBEEF, 1, 1};
        vecs[10] = '{0, 0, 32'h0,  32'h0,        1, 1, 32'h20, 32'h12345678, 1, 32'hBAD0BAD0,
                     0, 0, 32'h20, 32'h12345678, 0, 1, 32'h0,        32'hDEADBEEF, 1, 1};
        vecs[11] = '{0, 0, 32'h0,  32'h0,        0, 1, 32'h20, 32'h12345678, 1, 32'hBAD0BAD0,
                     0, 0, 32'h20, 32'h12345678, 0, 0, 32'h0,        32'hDEADBEEF, 1, 0};
        vecs[12] = '{1, 0, 32'h30, 32'h0,        0, 0, 32'h0,  32'h0,        1, 32'h0BADF00D,
                     1, 0, 32'h30, 32'h0,        0, 0, 32'h0,        32'hDEADBEEF, 0, 1};
        vecs[13] = '{1, 0, 32'h30, 32'h0,        0, 0, 32'h0,  32'h0,        1, 32'h0BADF00D,
                     0, 0, 32'h30, 32'h0,        1, 0, 32'h0BADF00D, 32'hDEADBEEF, 0, 1};
        vecs[14] = '{0, 0, 32'h30, 32'h0,        0, 0, 32'h0,  32'h0,        1, 32'h0BADF00D,
                     0, 0, 32'h30, 32'h0,        0, 0, 32'h0BADF00D, 32'hDEADBEEF, 0, 0};

        // Reset values, checked while reset is still asserted.
        iRst = 1'b1;
        clearInputs();
        stepCycle();
        stepCycle();
        checkBit("reset rr memRd", rrMemRd, 1'b0);
        checkBit("reset rr memWr", rrMemWr, 1'b0);
        checkOutput("reset rr memAddr", rrMemAddr, 32'h0);
        checkOutput("reset rr memWData", rrMemWData, 32'h0);
        checkBit("reset rr ack0", rrAck0, 1'b0);
        checkBit("reset rr ack1", rrAck1, 1'b0);
        checkOutput("reset rr rdata0", rrRData0, 32'h0);
        checkOutput("reset rr rdata1", rrRData1, 32'h0);
        checkBit("reset rr grant", rrGrant, 1'b1);
        checkBit("reset rr busy", rrBusy, 1'b0);
        checkBit("reset fp grant", fpGrant, 1'b1);
        checkBit("reset fp busy", fpBusy, 1'b0);
`ifdef DMEM_ARB_TIMEOUT_EN
        checkBit("reset rr timeout", rrTimeout, 1'b0);
`endif
        iRst = 1'b0;

        // Single-requester vectors: write, wait-state read, write, zero-wait read.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i]);
            stepCycle();
            checkDut("rr", i, vecs[i], rrMemRd, rrMemWr, rrMemAddr, rrMemWData,
                     rrAck0, rrAck1, rrRData0, rrRData1, rrGrant, rrBusy);
            checkDut("fp", i, vecs[i], fpMemRd, fpMemWr, fpMemAddr, fpMemWData,
                     fpAck0, fpAck1, fpRData0, fpRData1, fpGrant, fpBusy);
        end

        // Both ports request continuously with zero-wait memory.
        doReset();
        iReq0 = 1; iWr0 = 0; iAddr0 = 32'h100;
        iReq1 = 1; iWr1 = 0; iAddr1 = 32'h200;
        iMemAccessable = 1; iMemRData = 32'hCAFEF00D;
        for (int k = 1; k <= 12; k++) begin
            int   phase;
            logic rrWin;
            stepCycle();
            phase = (k - 1) % 3;
            rrWin = logic'(((k - 1) / 3) % 2);
            checkBit($sformatf("contend rr memRd k%0d", k), rrMemRd, phase == 0);
            checkBit($sformatf("contend rr ack0 k%0d", k), rrAck0, phase == 1 && !rrWin);
            checkBit($sformatf("contend rr ack1 k%0d", k), rrAck1, phase == 1 && rrWin);
            checkBit($sformatf("contend rr grant k%0d", k), rrGrant, rrWin);
            checkBit($sformatf("contend fp memRd k%0d", k), fpMemRd, phase == 0);
            checkBit($sformatf("contend fp ack0 k%0d", k), fpAck0, phase == 1);
            checkBit($sformatf("contend fp ack1 k%0d", k), fpAck1, 1'b0);
            checkBit($sformatf("contend fp grant k%0d", k), fpGrant, 1'b0);
            checkBit($sformatf("contend rr strobe overlap k%0d", k), rrMemRd & rrMemWr, 1'b0);
            checkBit($sformatf("contend rr ack overlap k%0d", k), rrAck0 & rrAck1, 1'b0);
            if (phase == 0) begin
                checkOutput($sformatf("contend rr memAddr k%0d", k), rrMemAddr,
                            rrWin ? 32'h200 : 32'h100);
                checkOutput($sformatf("contend fp memAddr k%0d", k), fpMemAddr, 32'h100);
            end
        end
        iReq0 = 0; iReq1 = 0;

        // Reset in the middle of a stalled write drops the strobe at once.
        doReset();
        iReq0 = 1; iWr0 = 1; iAddr0 = 32'h40; iWData0 = 32'h0F0F0F0F;
        iMemAccessable = 0;
        stepCycle();
        checkBit("midrst rr memWr before", rrMemWr, 1'b1);
        checkBit("midrst fp memWr before", fpMemWr, 1'b1);
        #2;
        iRst = 1'b1;
        #1;
        checkBit("midrst rr memWr async", rrMemWr, 1'b0);
        checkBit("midrst fp memWr async", fpMemWr, 1'b0);
        checkBit("midrst rr busy async", rrBusy, 1'b0);
        checkBit("midrst rr ack0 async", rrAck0, 1'b0);
        iReq0 = 0;
        stepCycle();
        iRst = 1'b0;
        iMemAccessable = 1;
        for (int k = 0; k < 2; k++) begin
            stepCycle();
            checkBit($sformatf("midrst rr busy after k%0d", k), rrBusy, 1'b0);
            checkBit($sformatf("midrst rr ack0 after k%0d", k), rrAck0, 1'b0);
            checkBit($sformatf("midrst rr memWr after k%0d", k), rrMemWr, 1'b0);
            checkBit($sformatf("midrst fp ack0 after k%0d", k), fpAck0, 1'b0);
        end

`ifdef DMEM_ARB_TIMEOUT_EN
        // Prime oRData0, then let a read hang until the watchdog fires.
        doReset();
        iReq0 = 1; iWr0 = 0; iAddr0 = 32'h50;
        iMemAccessable = 1; iMemRData = 32'h11112222;
        stepCycle();
        stepCycle();
        checkOutput("timeout prime rdata0", rrRData0, 32'h11112222);
        iReq0 = 0;
        stepCycle();
        iReq0 = 1; iMemAccessable = 0; iMemRData = 32'h99999999;
        for (int k = 1; k <= 6; k++) begin
            stepCycle();
            checkBit($sformatf("timeout rr memRd k%0d", k), rrMemRd, k <= 4);
            checkBit($sformatf("timeout rr ack0 k%0d", k), rrAck0, k == 5);
            checkBit($sformatf("timeout rr flag k%0d", k), rrTimeout, k == 5);
            checkBit($sformatf("timeout fp flag k%0d", k), fpTimeout, k == 5);
            checkBit($sformatf("timeout rr busy k%0d", k), rrBusy, k <= 5);
            checkOutput($sformatf("timeout rr rdata0 k%0d", k), rrRData0, 32'h11112222);
            if (k == 5) iReq0 = 0;
        end
`else
        // Without the watchdog a stalled access stays in BUSY indefinitely.
        doReset();
        iReq0 = 1; iWr0 = 0; iAddr0 = 32'h50;
        iMemAccessable = 0;
        for (int k = 1; k <= 20; k++) begin
            stepCycle();
            if (k == 1 || k == 20) begin
                checkBit($sformatf("stall rr memRd k%0d", k), rrMemRd, 1'b1);
                checkBit($sformatf("stall rr busy k%0d", k), rrBusy, 1'b1);
                checkBit($sformatf("stall rr ack0 k%0d", k), rrAck0, 1'b0);
            end
        end
        doReset();
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
